io_input_port: RTL

- Memory-mapped input peripheral: the read-side counterpart of the write-only output port on the I/O chip-select (decoder output y2, address 0x4000-0x5FFF).
- Synchronises and debounces WIDTH external pins.
- Captures rising and falling edges in sticky flags.
- The CPU reads status through the data bus during MemRead cycles and clears flags write-1-to-clear via MemWrite.

---
 rtl/io_pkg.sv | 16 +
 rtl/io_input_port_debounce.sv | 64 ++++++
 rtl/io_input_port.sv | 111 +++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// io_pkg: constants shared by the I/O input port and its sub-modules.
//   io_ofs_e : word offsets (addr[4:2]) of the input-port registers.
//   IO_BASE  : base address of the I/O chip-select window (decoder y2).
package io_pkg;

  typedef enum logic [2:0] {
    IO_OFS_LEVEL = 3'd0,
    IO_OFS_RISE  = 3'd1,
    IO_OFS_FALL  = 3'd2,
    IO_OFS_SYNC  = 3'd3,
    IO_OFS_MASK  = 3'd4
  } io_ofs_e;

  localparam logic [15:0] IO_BASE = 16'h4000;

endpackage

// File: rtl/io_input_port_debounce.sv
// debounce_cell: one input pin -> 2-FF synchroniser -> debounced level.
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   pin_i          asynchronous external pin
//   sync_o         second synchroniser stage
//   level_o        debounced level
//   rise_pulse_o   high in the cycle level_o is about to go 0->1
//   fall_pulse_o   high in the cycle level_o is about to go 1->0
module debounce_cell #(
  parameter int unsigned DEB_CYCLES = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic sync_o,
  output logic level_o,
  output logic rise_pulse_o,
  output logic fall_pulse_o
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             toggle;

  // Counter runs only while the synchronised pin disagrees with the accepted
  // level; any agreement discards the partial count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    toggle  = 1'b0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        toggle  = 1'b1;
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= pin_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_o       = sync_q;
  assign level_o      = level_q;
  assign rise_pulse_o = toggle & ~level_q;
  assign fall_pulse_o = toggle &  level_q;

endmodule

// File: rtl/io_input_port.sv
// io_input_port: memory-mapped input peripheral on the I/O chip-select.
//   clk, rst      system clock, synchronous active-high reset
//   nce, re, we   chip enable (active low), MemRead, MemWrite strobes
//   addr, wdata   byte address in the I/O window (addr[4:2] decoded), write data
//   rdata         combinational read data, 0 when not selected for read
//   portIn        WIDTH asynchronous pins
//   irq           interrupt request (only when IO_IRQ_EN is defined)
// Registers: LEVEL(RO) RISE(W1C) FALL(W1C) SYNC(RO) MASK(RW, IO_IRQ_EN only).
// Build option: IO_IRQ_EN adds the MASK register and the irq output.
module io_input_port
  import io_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEB_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             nce,
  input  logic             re,
  input  logic             we,
  input  logic [10:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] portIn
`ifdef IO_IRQ_EN
  ,
  output logic             irq
`endif
);

  logic [WIDTH-1:0] sync_w, level_w, rise_set, fall_set;
  logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [2:0]       ofs;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    debounce_cell #(.DEB_CYCLES(DEB_CYCLES)) u_cell (
      .clk_i        (clk),
      .rst_i        (rst),
      .pin_i        (portIn[i]),
      .sync_o       (sync_w[i]),
      .level_o      (level_w[i]),
      .rise_pulse_o (rise_set[i]),
      .fall_pulse_o (fall_set[i])
    );
  end

  assign ofs   = addr[4:2];
  assign wr_en = ~nce & we;

  // A new edge in the same cycle as a W1C of that bit keeps the flag set.
  always_comb begin
    rise_d = rise_q | rise_set;
    fall_d = fall_q | fall_set;
    if (wr_en && ofs == IO_OFS_RISE) rise_d = (rise_q & ~wdata[WIDTH-1:0]) | rise_set;
    if (wr_en && ofs == IO_OFS_FALL) fall_d = (fall_q & ~wdata[WIDTH-1:0]) | fall_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

`ifdef IO_IRQ_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             irq_q;

  always_comb begin
    mask_d = mask_q;
    if (wr_en && ofs == IO_OFS_MASK) mask_d = wdata[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= |((rise_q | fall_q) & mask_q);
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    rdata = '0;
    if (!nce && re) begin
      case (ofs)
        IO_OFS_LEVEL: rdata[WIDTH-1:0] = level_w;
        IO_OFS_RISE:  rdata[WIDTH-1:0] = rise_q;
        IO_OFS_FALL:  rdata[WIDTH-1:0] = fall_q;
        IO_OFS_SYNC:  rdata[WIDTH-1:0] = sync_w;
`ifdef IO_IRQ_EN
        IO_OFS_MASK:  rdata[WIDTH-1:0] = mask_q;
`endif
        default:      rdata = '0;
      endcase
    end
  end

  // Address bits outside addr[4:2] and wdata bits above WIDTH are don't-care.
  logic unused_ok;
  assign unused_ok = ^{addr[10:5], addr[1:0], wdata, IO_BASE};

endmodule
